// File: rtl/period_meter.sv
// rtl/period_meter.sv - period, high-time and lock monitor for a slow asynchronous square wave
module period_meter #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_shadow;
  logic [CNT_W-1:0] prev;
  logic [MW-1:0]    match_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   pdiff;
  logic             match;

  // s1/s2 resynchronise sig_in; s3 is the one-cycle history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // one bit wider so a period of exactly 2^CNT_W still compares correctly
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign pdiff   = (cnt_inc >= {1'b0, prev}) ? (cnt_inc - {1'b0, prev})
                                             : ({1'b0, prev} - cnt_inc);
  assign match   = (pdiff <= TOL_W);

  // measurement FSM: counts between rises, captures results and tracks lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_shadow <= '0;
      prev      <= '0;
      match_cnt <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        locked    <= 1'b0;
        match_cnt <= '0;
      end else if (state == IDLE) begin
        // first rise only opens the window; nothing to report yet
        cnt <= '0;
        if (rise) state <= MEASURE;
      end else begin
        if (rise) begin
          period    <= cnt_inc[CNT_W-1:0];
          high_time <= hi_shadow;
          prev      <= cnt_inc[CNT_W-1:0];
          valid     <= 1'b1;
          overflow  <= 1'b0;
          cnt       <= '0;
          if (match_cnt == '0) begin
            match_cnt <= MW'(1);
          end else if (match) begin
            if (match_cnt != LOCK_MAX) match_cnt <= match_cnt + MW'(1);
            if (match_cnt >= LOCK_MAX - MW'(1)) locked <= 1'b1;
          end else begin
            match_cnt <= MW'(1);
            locked    <= 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          // no rise within the counter range: give up and wait for a fresh start
          overflow  <= 1'b1;
          locked    <= 1'b0;
          match_cnt <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          cnt <= cnt_inc[CNT_W-1:0];
          if (fall) hi_shadow <= cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;

  localparam int W  = 8;
  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic [W-1:0] period0, high0, period4, high4;
  logic valid0, locked0, ovf0, valid4, locked4, ovf4;

  typedef struct {
    int p;
    int h;
    int l0;
    int l4;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int armed = 0;
  int last_rise = 0;
  int last_high = 0;
  int mc0 = 0;
  int mc4 = 0;
  int prev_p = 0;
  int last_p = 0;
  int r;

  period_meter #(.CNT_W(W), .LOCK_COUNT(LC), .TOL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period0), .high_time(high0), .valid(valid0),
    .locked(locked0), .overflow(ovf0)
  );

  period_meter #(.CNT_W(W), .LOCK_COUNT(LC), .TOL(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period4), .high_time(high4), .valid(valid4),
    .locked(locked4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int lock_step(input int mc, input int d, input int tol);
    if (mc == 0) return 1;
    if (d <= tol) return (mc < LC) ? mc + 1 : LC;
    return 1;
  endfunction

  task automatic push_exp(input int p, input int h);
    exp_t x;
    int d;
    d = p - prev_p;
    if (d < 0) d = -d;
    mc0 = lock_step(mc0, d, 0);
    mc4 = lock_step(mc4, d, 4);
    prev_p = p;
    last_p = p;
    x.p = p;
    x.h = h;
    x.l0 = (mc0 == LC) ? 1 : 0;
    x.l4 = (mc4 == LC) ? 1 : 0;
    q.push_back(x);
  endtask

  task automatic disarm();
    armed = 0;
    mc0 = 0;
    mc4 = 0;
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    if (v && !sig_in) begin
      if (en) begin
        if (armed != 0) push_exp(cyc - last_rise, last_high);
        armed = 1;
        last_rise = cyc;
      end
    end else if (!v && sig_in) begin
      last_high = cyc - last_rise;
    end
    sig_in = v;
  endtask

  task automatic run(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge clk);
    en = v;
    if (!v) disarm();
  endtask

  // scoreboard: every valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && (valid0 || valid4)) begin
      chk("valid_pair", valid4, valid0);
      if (q.size() == 0) begin
        chk("unexpected_valid", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("period", period0, e.p);
        chk("high_time", high0, e.h);
        chk("locked_tol0", locked0, e.l0);
        chk("locked_tol4", locked4, e.l4);
        chk("period_tol4", period4, e.p);
        chk("overflow_on_valid", ovf0, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_period", period0, 0);
    chk("rst_high", high0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_locked", locked0, 0);
    chk("rst_overflow", ovf0, 0);
    rst = 1'b1;
    en = 1'b1;
    repeat (4) step(1'b0);

    run(10, 10, 6);
    chk("locked_div20", locked0, 1);
    run(12, 12, 6);
    run(3, 17, 5);
    run(1, 1, 8);

    // stuck low after a rise
    step(1'b1);
    r = cyc;
    repeat (9) step(1'b1);
    for (int k = 0; k < 400 && !ovf0; k++) step(1'b0);
    chk("ovf_delay", cyc - r, 259);
    chk("ovf_set", ovf0, 1);
    chk("ovf_tol4", ovf4, 1);
    chk("ovf_locked0", locked0, 0);
    chk("ovf_locked4", locked4, 0);
    chk("ovf_period_held", period0, last_p);
    disarm();
    run(10, 10, 1);
    chk("ovf_hold", ovf0, 1);
    run(10, 10, 5);
    chk("ovf_cleared", ovf0, 0);
    chk("relock", locked0, 1);

    // reset in the low half of a period
    repeat (10) step(1'b1);
    repeat (4) step(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_period", period0, 0);
    chk("mid_rst_high", high0, 0);
    chk("mid_rst_locked", locked0, 0);
    chk("mid_rst_valid", valid0, 0);
    disarm();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) step(1'b0);
    run(10, 10, 5);

    // enable dropped for 50 cycles while the input keeps toggling
    set_en(1'b0);
    run(10, 10, 2);
    repeat (9) step(1'b0);
    chk("en_low_locked", locked0, 0);
    chk("en_low_period", period0, last_p);
    set_en(1'b1);
    run(10, 10, 4);
    repeat (30) step(1'b0);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
